// File: rtl/mesh_pkg.sv
// Mesh packet layout constants and header construction shared by the mesh NIC blocks.
package mesh_pkg;

  localparam int unsigned PKT_W    = 64;
  localparam int unsigned HDR_W    = PKT_W - 1;
  localparam int unsigned COORD_W  = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 16;

  localparam int unsigned VC_BIT   = 63;
  localparam int unsigned DIRA_BIT = 62;
  localparam int unsigned DIRB_BIT = 61;
  localparam int unsigned HOPA_MSB = 55;
  localparam int unsigned HOPA_LSB = 52;
  localparam int unsigned HOPB_MSB = 51;
  localparam int unsigned HOPB_LSB = 48;
  localparam int unsigned SRC_MSB  = 47;
  localparam int unsigned SRC_LSB  = 32;
  localparam int unsigned DATA_MSB = 31;

  // Packet without the vc bit; vc is stamped at injection time.
  function automatic logic [HDR_W-1:0] build_hdr(
    input logic [COORD_W-1:0] src_a,
    input logic [COORD_W-1:0] src_b,
    input logic [COORD_W-1:0] dst_a,
    input logic [COORD_W-1:0] dst_b,
    input logic [DATA_W-1:0]  data
  );
    logic [2:0]       sa, sb, da, db, ha, hb;
    logic [HDR_W-1:0] p;
    sa = 3'(src_a);
    sb = 3'(src_b);
    da = 3'(dst_a);
    db = 3'(dst_b);
    ha = (da > sa) ? (da - sa) : (sa - da);
    hb = (db > sb) ? (db - sb) : (sb - db);
    p                      = '0;
    p[DIRA_BIT]            = (da > sa);
    p[DIRB_BIT]            = (db > sb);
    p[HOPA_MSB:HOPA_LSB]   = 4'(ha);
    p[HOPB_MSB:HOPB_LSB]   = 4'(hb);
    p[SRC_MSB:SRC_LSB]     = {6'b0, src_a, 6'b0, src_b};
    p[DATA_MSB:0]          = data;
    return p;
  endfunction

endpackage

// File: rtl/pe_nic_tx_if.sv
// PE request channel plus router PE-input channel of the NIC transmitter.
interface pe_nic_tx_if;
  import mesh_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_dst_a;
  logic [COORD_W-1:0] req_dst_b;
  logic [DATA_W-1:0]  req_data;
  logic               peri;
  logic               pesi;
  logic [PKT_W-1:0]   pedi;

  modport master (
    output req_valid, req_dst_a, req_dst_b, req_data, peri,
    input  req_ready, pesi, pedi
  );

  modport slave (
    input  req_valid, req_dst_a, req_dst_b, req_data, peri,
    output req_ready, pesi, pedi
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
module sync_fifo #(
  parameter int unsigned WIDTH = 63,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/pe_nic_tx.sv
// PE-side mesh NIC transmitter: builds headers at accept, queues them and injects
// into the local router PE port with the vc bit taken from the mesh polarity.
module pe_nic_tx
  import mesh_pkg::*;
#(
  parameter int unsigned SRC_A      = 1,
  parameter int unsigned SRC_B      = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  pe_nic_tx_if.slave       nic,
  output logic             drop,
  output logic [CNT_W-1:0] sent_count
);
  localparam logic [COORD_W-1:0] SRC_A_C = COORD_W'(SRC_A);
  localparam logic [COORD_W-1:0] SRC_B_C = COORD_W'(SRC_B);

  logic             full, empty, accept, is_self, push, pop;
  logic [HDR_W-1:0] wdata, head;

  logic             pesi_q, pesi_d;
  logic [PKT_W-1:0] pedi_q, pedi_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] sent_count_q, sent_count_d;

  sync_fifo #(
    .WIDTH (HDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Accept/drop decision and injection datapath.
  always_comb begin
    wdata        = build_hdr(SRC_A_C, SRC_B_C, nic.req_dst_a, nic.req_dst_b, nic.req_data);
    accept       = nic.req_valid && !full;
    is_self      = (nic.req_dst_a == SRC_A_C) && (nic.req_dst_b == SRC_B_C);
    push         = accept && !is_self;
    pop          = !empty && nic.peri;
    pesi_d       = pop;
    pedi_d       = pedi_q;
    if (pop) pedi_d = {polarity, head};
    drop_d       = accept && is_self;
    sent_count_d = sent_count_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pesi_q       <= 1'b0;
      pedi_q       <= '0;
      drop_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      pesi_q       <= pesi_d;
      pedi_q       <= pedi_d;
      drop_q       <= drop_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign nic.req_ready = !full;
  assign nic.pesi      = pesi_q;
  assign nic.pedi      = pedi_q;
  assign drop          = drop_q;
  assign sent_count    = sent_count_q;
endmodule

// File: tb/tb_pe_nic_tx.sv
// Directed bench for pe_nic_tx at SRC=(1,1), FIFO_DEPTH=4, with a cycle-level reference model.
module tb_pe_nic_tx;
  localparam int unsigned DEPTH = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        polarity = 1'b0;
  logic        drop;
  logic [15:0] sent_count;

  pe_nic_tx_if nif ();

  pe_nic_tx #(
    .SRC_A      (1),
    .SRC_B      (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .polarity   (polarity),
    .nic        (nif),
    .drop       (drop),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) polarity <= ~polarity;

  typedef struct {
    logic [1:0]  da;
    logic [1:0]  db;
    logic [31:0] data;
    logic [1:0]  dir;
    logic [7:0]  hops;
  } vec_t;

  vec_t        vecs [15];
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [62:0] exp_q [$];
  logic [15:0] sent_exp = '0;
  logic [62:0] cur_hdr = '0;
  logic        accepted;
  int          pesi_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Independent reference for the header of a request from node (1,1).
  function automatic logic [62:0] tb_hdr(input int da, input int db, input logic [31:0] d);
    int          ha, hb;
    logic [62:0] h;
    ha = (da > 1) ? da - 1 : 1 - da;
    hb = (db > 1) ? db - 1 : 1 - db;
    h        = '0;
    h[62]    = (da > 1);
    h[61]    = (db > 1);
    h[55:52] = 4'(ha);
    h[51:48] = 4'(hb);
    h[47:32] = 16'h0101;
    h[31:0]  = d;
    return h;
  endfunction

  task automatic set_req(input logic v, input logic [1:0] a, input logic [1:0] b, input logic [31:0] d);
    nif.req_valid = v;
    nif.req_dst_a = a;
    nif.req_dst_b = b;
    nif.req_data  = d;
    cur_hdr       = tb_hdr(int'(a), int'(b), d);
  endtask

  // One clock edge: predict from the model, then compare every output after the edge.
  task automatic cyc();
    int          s;
    logic        e_pesi, acc, self_req;
    logic [62:0] h;
    s        = exp_q.size();
    e_pesi   = nif.peri && (s > 0);
    acc      = nif.req_valid && (s < int'(DEPTH));
    self_req = (nif.req_dst_a == 2'd1) && (nif.req_dst_b == 2'd1);
    @(posedge clk);
    #1;
    if (nif.pesi) pesi_seen++;
    chk("pesi", 64'(nif.pesi), 64'(e_pesi));
    if (e_pesi) begin
      h = exp_q.pop_front();
      chk("pedi", nif.pedi, {~polarity, h});
      sent_exp++;
    end
    if (acc && !self_req) exp_q.push_back(cur_hdr);
    chk("drop", 64'(drop), 64'(acc && self_req));
    chk("sent_count", 64'(sent_count), 64'(sent_exp));
    chk("req_ready", 64'(nif.req_ready), 64'(exp_q.size() < int'(DEPTH)));
    accepted = acc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nif.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pesi", 64'(nif.pesi), 64'd0);
    chk("rst_pedi", nif.pedi, 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_sent", 64'(sent_count), 64'd0);
    chk("rst_ready", 64'(nif.req_ready), 64'd1);
    reset = 1'b0;
    exp_q.delete();
    sent_exp = '0;
  endtask

  initial begin
    int i, p0;
    vecs = '{
      '{2'd0, 2'd0, 32'h1111_1111, 2'b00, 8'h11},
      '{2'd0, 2'd1, 32'h2222_2222, 2'b00, 8'h10},
      '{2'd0, 2'd2, 32'h3333_3333, 2'b01, 8'h11},
      '{2'd0, 2'd3, 32'h4444_4444, 2'b01, 8'h12},
      '{2'd1, 2'd0, 32'h5555_5555, 2'b00, 8'h01},
      '{2'd1, 2'd2, 32'h6666_6666, 2'b01, 8'h01},
      '{2'd1, 2'd3, 32'h7777_7777, 2'b01, 8'h02},
      '{2'd2, 2'd0, 32'h8888_8888, 2'b10, 8'h11},
      '{2'd2, 2'd1, 32'h9999_9999, 2'b10, 8'h10},
      '{2'd2, 2'd2, 32'hAAAA_AAAA, 2'b11, 8'h11},
      '{2'd2, 2'd3, 32'hBBBB_BBBB, 2'b11, 8'h12},
      '{2'd3, 2'd0, 32'hCCCC_CCCC, 2'b10, 8'h21},
      '{2'd3, 2'd1, 32'hDDDD_DDDD, 2'b10, 8'h20},
      '{2'd3, 2'd2, 32'hEEEE_EEEE, 2'b11, 8'h21},
      '{2'd3, 2'd3, 32'hFFFF_FFFF, 2'b11, 8'h22}
    };
    nif.peri = 1'b0;
    set_req(1'b0, 2'd0, 2'd0, 32'h0);
    do_reset();

    // Single packet to (0,0): two-edge latency, one strobe.
    nif.peri = 1'b1;
    set_req(1'b1, 2'd0, 2'd0, 32'h0);
    cyc();
    nif.req_valid = 1'b0;
    p0 = pesi_seen;
    for (int c = 0; c < 3; c++) cyc();
    chk("t1_pulses", 64'(pesi_seen - p0), 64'd1);
    chk("t1_sent", 64'(sent_count), 64'd1);

    // Table-driven stream over all non-self destinations.
    do_reset();
    nif.peri = 1'b1;
    p0 = pesi_seen;
    for (int k = 0; k < 15; k++) begin
      set_req(1'b1, vecs[k].da, vecs[k].db, vecs[k].data);
      cur_hdr = {vecs[k].dir, 5'b0, vecs[k].hops, 16'h0101, vecs[k].data};
      cyc();
    end
    nif.req_valid = 1'b0;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) cyc();
    cyc();
    chk("t2_pulses", 64'(pesi_seen - p0), 64'd15);
    chk("t2_sent", 64'(sent_count), 64'd15);

    // Stall with a full FIFO, then release.
    nif.peri = 1'b0;
    i = 0;
    p0 = pesi_seen;
    for (int c = 0; c < 6; c++) begin
      set_req(1'b1, 2'(i), 2'd3, 32'hA000_0000 + 32'(i));
      cyc();
      if (accepted) i++;
    end
    chk("t3_ready_low", 64'(nif.req_ready), 64'd0);
    chk("t3_no_pesi", 64'(pesi_seen - p0), 64'd0);
    nif.peri = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (accepted) begin
        i++;
        nif.req_valid = 1'b0;
      end
    end
    chk("t3_burst", 64'(pesi_seen - p0), 64'd4);
    chk("t3_fifth", 64'(i), 64'd5);
    nif.req_valid = 1'b0;
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) cyc();

    // Self-addressed request is swallowed.
    p0 = pesi_seen;
    set_req(1'b1, 2'd1, 2'd1, 32'hDEAD_BEEF);
    cyc();
    nif.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    chk("t4_no_pesi", 64'(pesi_seen - p0), 64'd0);

    // Six packets under a toggling peri.
    i = 0;
    p0 = pesi_seen;
    for (int c = 0; c < 40; c++) begin
      nif.peri = (c % 2 == 0);
      if (i < 6) set_req(1'b1, 2'(i % 4), 2'd0, 32'h5000_0000 + 32'(i));
      else nif.req_valid = 1'b0;
      cyc();
      if (accepted) i++;
      if (i == 6 && exp_q.size() == 0) break;
    end
    chk("t5_pulses", 64'(pesi_seen - p0), 64'd6);

    // Reset with packets queued: nothing stale afterwards.
    nif.peri = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, 2'd2, 2'(c), 32'h6000_0000 + 32'(c));
      cyc();
    end
    do_reset();
    nif.peri = 1'b1;
    p0 = pesi_seen;
    for (int c = 0; c < 4; c++) cyc();
    chk("t6_no_stale", 64'(pesi_seen - p0), 64'd0);

    chk("model_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
